// File: rtl/cl_axi_sram_slv_pkg.sv
// Shared widths, response codes, FSM state types and burst context for the AXI4 SRAM slave.
package cl_axi_sram_slv_pkg;

  localparam int unsigned DATA_W   = 512;
  localparam int unsigned STRB_W   = 64;
  localparam int unsigned ID_W     = 16;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned BEAT_OFS = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_64B    = 3'b110;

  typedef logic [LEN_W-1:0] len_t;
  typedef logic [LEN_W:0]   cnt_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    len_t            len;
    logic            err;
  } burst_t;

  // Burst is rejected when it addresses beyond the memory or is not full-width.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input logic [2:0] size,
                                    input int unsigned idx_w);
    return ((addr >> (BEAT_OFS + idx_w)) != '0) || (size != SIZE_64B);
  endfunction

endpackage

// File: rtl/cl_axi_sram_slv_mem.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, read-first on collision.
module cl_axi_sram_slv_mem
  import cl_axi_sram_slv_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  // rdata holds its value while re is low; the read controller relies on that as a stall buffer.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/cl_axi_sram_slv.sv
// AXI4 INCR-burst slave over on-chip SRAM, independent read and write engines.
// Define CL_AXI_SRAM_SLV_WLAST_CHK_EN to flag wlast/beat-count mismatches on err_wlast.
module cl_axi_sram_slv
  import cl_axi_sram_slv_pkg::*;
#(
  parameter int unsigned MEM_IDX_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              err_wlast
);

  localparam int unsigned IW = MEM_IDX_W;
  typedef logic [IW-1:0] idx_t;

  w_state_e   w_state, w_state_d;
  burst_t     w_ctx, w_ctx_d;
  idx_t       w_idx, w_idx_d;
  len_t       w_beat, w_beat_d;
  logic       w_lerr, w_lerr_d, err_wlast_q, err_wlast_d;
  logic       awready_d, wready_d, bvalid_d, w_fire, wl_bad;
  logic [1:0] bresp_d;

  r_state_e          r_state, r_state_d;
  burst_t            r_ctx, r_ctx_d;
  idx_t              r_idx, r_idx_d, rd_idx;
  cnt_t              i_cnt, i_cnt_d;
  len_t              o_cnt, o_cnt_d;
  logic              m_vld, m_vld_d, issue, o_load;
  logic              arready_d, rvalid_d, rlast_d;
  logic [1:0]        rresp_d;
  logic [DATA_W-1:0] rdata_d, mem_rdata;

  assign bid       = w_ctx.id;
  assign rid       = r_ctx.id;
  assign err_wlast = err_wlast_q;

`ifdef CL_AXI_SRAM_SLV_WLAST_CHK_EN
  logic unused;
  assign unused = ^wid;
`else
  logic unused;
  assign unused = ^{wid, wlast};
`endif

  cl_axi_sram_slv_mem #(.IDX_W(IW)) u_mem (
    .clk   (clk),
    .we    (w_fire && !w_ctx.err),
    .widx  (w_idx),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (issue),
    .ridx  (rd_idx),
    .rdata (mem_rdata)
  );

  // Write engine: AW capture, beat counting, single B response.
  always_comb begin
    w_state_d   = w_state;
    w_ctx_d     = w_ctx;
    w_idx_d     = w_idx;
    w_beat_d    = w_beat;
    w_lerr_d    = w_lerr;
    bresp_d     = bresp;
    err_wlast_d = err_wlast_q;
    w_fire      = 1'b0;
    wl_bad      = 1'b0;
    case (w_state)
      W_IDLE: if (awvalid && awready) begin
        w_ctx_d.id  = awid;
        w_ctx_d.len = awlen;
        w_ctx_d.err = addr_err(awaddr, awsize, IW);
        w_idx_d     = awaddr[BEAT_OFS +: IW];
        w_beat_d    = '0;
        w_lerr_d    = 1'b0;
        w_state_d   = W_DATA;
      end
      W_DATA: if (wvalid && wready) begin
        w_fire = 1'b1;
`ifdef CL_AXI_SRAM_SLV_WLAST_CHK_EN
        wl_bad = wlast != (w_beat == w_ctx.len);
`endif
        w_idx_d  = w_idx + idx_t'(1);
        w_beat_d = w_beat + len_t'(1);
        if (wl_bad) begin
          w_lerr_d    = 1'b1;
          err_wlast_d = 1'b1;
        end
        if (w_beat == w_ctx.len) begin
          w_state_d = W_RESP;
          bresp_d   = (w_ctx.err || w_lerr || wl_bad) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (bvalid && bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read engine: mem output register is the one-entry prefetch in front of the R registers.
  always_comb begin
    r_state_d = r_state;
    r_ctx_d   = r_ctx;
    r_idx_d   = r_idx;
    rd_idx    = r_idx;
    i_cnt_d   = i_cnt;
    o_cnt_d   = o_cnt;
    rresp_d   = rresp;
    rdata_d   = rdata;
    rlast_d   = rlast;
    issue     = 1'b0;
    o_load    = m_vld && (!rvalid || rready);
    rvalid_d  = o_load || (rvalid && !rready);
    case (r_state)
      R_IDLE: if (arvalid && arready) begin
        r_ctx_d.id  = arid;
        r_ctx_d.len = arlen;
        r_ctx_d.err = addr_err(araddr, arsize, IW);
        rd_idx      = araddr[BEAT_OFS +: IW];
        issue       = 1'b1;
        r_idx_d     = rd_idx + idx_t'(1);
        i_cnt_d     = cnt_t'(1);
        o_cnt_d     = '0;
        rresp_d     = r_ctx_d.err ? RESP_SLVERR : RESP_OKAY;
        r_state_d   = R_DATA;
      end
      R_DATA: begin
        if ((i_cnt <= {1'b0, r_ctx.len}) && (!m_vld || o_load)) begin
          issue   = 1'b1;
          r_idx_d = r_idx + idx_t'(1);
          i_cnt_d = i_cnt + cnt_t'(1);
        end
        if (rvalid && rready && rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    m_vld_d = issue || (m_vld && !o_load);
    if (o_load) begin
      rdata_d = r_ctx.err ? '0 : mem_rdata;
      rlast_d = (o_cnt == r_ctx.len);
      o_cnt_d = o_cnt + len_t'(1);
    end else if (rvalid && rready) begin
      rlast_d = 1'b0;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  // State and output registers; memory contents are deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      w_ctx       <= '0;
      w_idx       <= '0;
      w_beat      <= '0;
      w_lerr      <= 1'b0;
      err_wlast_q <= 1'b0;
      awready     <= 1'b0;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      r_state     <= R_IDLE;
      r_ctx       <= '0;
      r_idx       <= '0;
      i_cnt       <= '0;
      o_cnt       <= '0;
      m_vld       <= 1'b0;
      arready     <= 1'b0;
      rvalid      <= 1'b0;
      rlast       <= 1'b0;
      rresp       <= RESP_OKAY;
      rdata       <= '0;
    end else begin
      w_state     <= w_state_d;
      w_ctx       <= w_ctx_d;
      w_idx       <= w_idx_d;
      w_beat      <= w_beat_d;
      w_lerr      <= w_lerr_d;
      err_wlast_q <= err_wlast_d;
      awready     <= awready_d;
      wready      <= wready_d;
      bvalid      <= bvalid_d;
      bresp       <= bresp_d;
      r_state     <= r_state_d;
      r_ctx       <= r_ctx_d;
      r_idx       <= r_idx_d;
      i_cnt       <= i_cnt_d;
      o_cnt       <= o_cnt_d;
      m_vld       <= m_vld_d;
      arready     <= arready_d;
      rvalid      <= rvalid_d;
      rlast       <= rlast_d;
      rresp       <= rresp_d;
      rdata       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cl_axi_sram_slv.sv
// Directed bench for cl_axi_sram_slv: single beat, wrap, strobes, errors, backpressure, wlast, reset.
module tb_cl_axi_sram_slv;
  import cl_axi_sram_slv_pkg::*;

  localparam int unsigned IW = 10;
  localparam int NWORDS = 1 << IW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ID_W-1:0]   awid, wid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [LEN_W-1:0]  awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rlast, rvalid, rready, err_wlast;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;
  logic [1:0]        bresp, rresp;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] model [int];

  cl_axi_sram_slv #(.MEM_IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_wlast(err_wlast)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required end of test");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Seed < 0 gives all-ones; otherwise every 32-bit lane encodes seed/beat/lane.
  function automatic logic [DATA_W-1:0] pat(input int seed, input int beat);
    logic [DATA_W-1:0] v;
    if (seed < 0) return '1;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = {8'(seed), 8'(beat), 8'(k), 8'hA5};
    return v;
  endfunction

  task automatic chk_reset(input string p);
    chk({p, ".awready"}, awready, 0);
    chk({p, ".wready"}, wready, 0);
    chk({p, ".bvalid"}, bvalid, 0);
    chk({p, ".arready"}, arready, 0);
    chk({p, ".rvalid"}, rvalid, 0);
    chk({p, ".rlast"}, rlast, 0);
    chk({p, ".err_wlast"}, err_wlast, 0);
    chk({p, ".bid"}, bid, 0);
    chk({p, ".rid"}, rid, 0);
    chk({p, ".bresp"}, bresp, 0);
    chk({p, ".rresp"}, rresp, 0);
    chk({p, ".rdata"}, rdata, 0);
  endtask

  task automatic axi_write(input logic [15:0] id, input logic [63:0] addr, input int len,
                           input logic [2:0] size, input int seed, input logic [STRB_W-1:0] strb,
                           input logic [1:0] exp_resp, input bit upd, input bit bp, input int early_last);
    int t, w0, w;
    logic [DATA_W-1:0] d, m;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_timeout", t < 50, 1);
    @(negedge clk);
    awvalid = 1'b0;
    w0 = int'(addr[BEAT_OFS +: IW]);
    for (int i = 0; i <= len; i++) begin
      d = pat(seed, i);
      wvalid = 1'b1; wdata = d; wstrb = strb; wid = id;
      wlast = (early_last >= 0) ? (i == early_last) : (i == len);
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      chk("w_timeout", t < 50, 1);
      @(negedge clk);
      if (upd) begin
        w = (w0 + i) % NWORDS;
        m = model.exists(w) ? model[w] : '0;
        for (int b = 0; b < STRB_W; b++) if (strb[b]) m[b*8 +: 8] = d[b*8 +: 8];
        model[w] = m;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_latency", bvalid, 1);
    t = 0;
    while (t < 100) begin
      bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bvalid) begin
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
      end
      if (bvalid && bready) break;
      @(negedge clk); t++;
    end
    chk("b_timeout", t < 100, 1);
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic axi_read(input logic [15:0] id, input logic [63:0] addr, input int len,
                          input bit err, input bit bp);
    int t, beat, w0;
    logic [DATA_W-1:0] e;
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = SIZE_64B; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_timeout", t < 50, 1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_early", rvalid, 0);
    @(negedge clk);
    chk("rvalid_latency", rvalid, 1);
    w0 = int'(addr[BEAT_OFS +: IW]);
    beat = 0; t = 0;
    while (beat <= len && t < 3000) begin
      rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid) begin
        if (err) e = '0;
        else e = model[(w0 + beat) % NWORDS];
        chk("rdata", rdata, e);
        chk("rlast", rlast, beat == len);
        chk("rresp", rresp, err ? RESP_SLVERR : RESP_OKAY);
        chk("rid", rid, id);
        if (rready) beat++;
      end
      @(negedge clk); t++;
    end
    rready = 1'b0;
    chk("r_timeout", t < 3000, 1);
    if (!bp) chk("r_stream_cycles", t, len + 1);
    chk("rvalid_after_last", rvalid, 0);
  endtask

  initial begin
    logic [1:0] exp_wl_resp;
    logic       exp_wl_flag;
    int t, beats;
`ifdef CL_AXI_SRAM_SLV_WLAST_CHK_EN
    exp_wl_resp = RESP_SLVERR; exp_wl_flag = 1'b1;
`else
    exp_wl_resp = RESP_OKAY;   exp_wl_flag = 1'b0;
`endif
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("awready_after_reset", awready, 1);
    chk("arready_after_reset", arready, 1);

    // Single beat write/read.
    axi_write(16'h1234, 64'h40, 0, SIZE_64B, 1, '1, RESP_OKAY, 1, 0, -1);
    axi_read(16'h0BCD, 64'h40, 0, 0, 0);

    // 256 beats starting two words before the top: index wraps to 0.
    axi_write(16'h0002, 64'hFF80, 255, SIZE_64B, 2, '1, RESP_OKAY, 1, 0, -1);
    axi_read(16'h0003, 64'hFF80, 255, 0, 0);

    // Partial strobe over all-ones data.
    axi_write(16'h0004, 64'h80, 0, SIZE_64B, -1, '1, RESP_OKAY, 1, 0, -1);
    axi_write(16'h0004, 64'h80, 0, SIZE_64B, 3, 64'hFF, RESP_OKAY, 1, 0, -1);
    axi_read(16'h0005, 64'h80, 0, 0, 0);

    // Error bursts: out-of-range read, narrow write, out-of-range write.
    axi_read(16'h0006, 64'h1_0000_0000, 3, 1, 0);
    axi_write(16'h0007, 64'h40, 0, 3'b101, 7, '1, RESP_SLVERR, 0, 0, -1);
    axi_write(16'h0008, 64'h1_0040, 0, SIZE_64B, 8, '1, RESP_SLVERR, 0, 0, -1);
    axi_read(16'h0009, 64'h40, 0, 0, 0);

    // Backpressure on B and R during 16-beat bursts.
    axi_write(16'h00A1, 64'h1000, 15, SIZE_64B, 9, '1, RESP_OKAY, 1, 1, -1);
    axi_read(16'h00A2, 64'h1000, 15, 0, 1);

    // wlast asserted on beat 2 of 4.
    axi_write(16'h00B1, 64'h2000, 3, SIZE_64B, 11, '1, exp_wl_resp, 1, 0, 1);
    chk("err_wlast", err_wlast, exp_wl_flag);
    axi_read(16'h00B2, 64'h2000, 3, 0, 0);

    // Reset during beat 5 of 8 with a write burst also in flight.
    @(negedge clk);
    awid = 16'h00C1; awaddr = 64'h3000; awlen = 8'd7; awsize = SIZE_64B; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = pat(12, 0); wstrb = '1; wlast = 1'b0;
    repeat (2) @(negedge clk);
    wvalid = 1'b0;
    arid = 16'h00C2; araddr = 64'hFF80; arlen = 8'd7; arsize = SIZE_64B; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 1'b0;
    beats = 0; t = 0;
    while (beats < 4 && t < 50) begin
      if (rvalid) beats++;
      @(negedge clk); t++;
    end
    chk("mid_burst_rvalid", rvalid, 1);
    chk("mid_burst_wready", wready, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    rready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("awready_after_mid_reset", awready, 1);
    chk("arready_after_mid_reset", arready, 1);
    axi_write(16'h00D1, 64'h4000, 3, SIZE_64B, 14, '1, RESP_OKAY, 1, 0, -1);
    axi_read(16'h00D2, 64'h4000, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
